dma_xfer_engine: RTL and testbench

DMA_XFER_ENGINE -- requirements
Module: dma_xfer_engine

---
 rtl/dma_xfer_engine.sv | 167 ++++++++++++++++
 tb/tb_dma_xfer_engine.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dma_xfer_engine.sv
// Word-interleaved DMA engine bridging write/read streams to a 4-bank crossbar port.
// Optional range check enabled by defining DMA_XFER_RANGE_CHECK_EN.
module dma_xfer_engine #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned NB     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [ADDR_W+1:0] cmd_addr,
  input  logic [ADDR_W+2:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              dma_write_en,
  output logic              dma_read_en,
  output logic [1:0]        dma_bank_sel,
  output logic [ADDR_W-1:0] dma_local_addr,
  output logic [DATA_W-1:0] dma_data_in,
  input  logic [DATA_W-1:0] dma_data_out
);

  localparam int unsigned BankW = $clog2(NB);
  localparam int unsigned AW    = ADDR_W + 2;
  localparam int unsigned LW    = ADDR_W + 3;

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StDrain} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [LW-1:0]     rem_q, rem_d;
  logic              inflight_q, inflight_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              rdy_q;
  logic [DATA_W-1:0] mem_q [2];
  logic [DATA_W-1:0] mem_d [2];
  logic              wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]        cnt_q, cnt_d;

  logic       cmd_fire, wr_beat, pop, rd_issue, drain_done, range_bad, en_any;
  logic [2:0] occ_eff;

`ifdef DMA_XFER_RANGE_CHECK_EN
  localparam logic [ADDR_W+3:0] Span = (ADDR_W+4)'(NB) << ADDR_W;
  logic [ADDR_W+3:0] end_addr;
  assign end_addr  = (ADDR_W+4)'(cmd_addr) + (ADDR_W+4)'(cmd_len);
  assign range_bad = end_addr > Span;
`else
  assign range_bad = 1'b0;
`endif

  assign cmd_fire   = cmd_valid & cmd_ready;
  assign wr_beat    = (state_q == StWrite) & wr_valid;
  assign pop        = (cnt_q != 2'd0) & rd_ready;
  // The word leaving the FIFO this cycle frees its slot, which keeps reads at one per cycle.
  assign occ_eff    = 3'(cnt_q) + 3'(inflight_q) - 3'(pop);
  assign rd_issue   = (state_q == StRead) & (rem_q != '0) & (occ_eff < 3'd2);
  assign drain_done = (state_q == StDrain) & (cnt_q == 2'd0) & ~inflight_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    inflight_d = rd_issue;
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    cnt_d      = cnt_q + 2'(inflight_q) - 2'(pop);
    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          if (range_bad) begin
            err_d = 1'b1;
          end else if (cmd_len == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d  = cmd_addr;
            rem_d   = cmd_len;
            state_d = cmd_dir ? StRead : StWrite;
          end
        end
      end
      StWrite: begin
        if (wr_beat) begin
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - LW'(1);
          if (rem_q == LW'(1)) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end
        end
      end
      StRead: begin
        if (rd_issue) begin
          addr_d = addr_q + AW'(1);
          rem_d  = rem_q - LW'(1);
          if (rem_q == LW'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (drain_done) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (inflight_q) begin
      mem_d[wptr_q] = dma_data_out;
      wptr_d        = ~wptr_q;
    end
    if (pop) rptr_d = ~rptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rdy_q      <= 1'b0;
      mem_q[0]   <= '0;
      mem_q[1]   <= '0;
      wptr_q     <= 1'b0;
      rptr_q     <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= inflight_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rdy_q      <= 1'b1;
      mem_q      <= mem_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign en_any         = wr_beat | rd_issue;
  assign cmd_ready      = rdy_q & (state_q == StIdle);
  assign wr_ready       = (state_q == StWrite);
  assign rd_valid       = (cnt_q != 2'd0);
  assign rd_data        = mem_q[rptr_q];
  assign busy           = (state_q != StIdle);
  assign done           = done_q | drain_done;
  assign err            = err_q;
  assign dma_write_en   = wr_beat;
  assign dma_read_en    = rd_issue;
  assign dma_bank_sel   = en_any ? addr_q[BankW-1:0] : 2'b00;
  assign dma_local_addr = en_any ? addr_q[ADDR_W+BankW-1:BankW] : '0;
  assign dma_data_in    = wr_beat ? wr_data : '0;

endmodule

// File: tb/tb_dma_xfer_engine.sv
// Scoreboard bench for dma_xfer_engine with a behavioural 4-bank memory model.
module tb_dma_xfer_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_dir;
  logic [11:0] cmd_addr;
  logic [12:0] cmd_len;
  logic        wr_valid, wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid, rd_ready;
  logic [31:0] rd_data;
  logic        busy, done, err;
  logic        dma_write_en, dma_read_en;
  logic [1:0]  dma_bank_sel;
  logic [9:0]  dma_local_addr;
  logic [31:0] dma_data_in, dma_data_out;

  int checks = 0;
  int failures = 0;

  logic [43:0] exp_wr[$];
  logic [31:0] exp_rd[$];
  int exp_done = 0;
  int exp_err = 0;
  int reads_left = 0;
  int m_occ = 0;
  int m_infl = 0;

  logic [31:0] mem [4096];
  bit          loaded = 1'b0;

  dma_xfer_engine dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done), .err(err),
    .dma_write_en(dma_write_en), .dma_read_en(dma_read_en),
    .dma_bank_sel(dma_bank_sel), .dma_local_addr(dma_local_addr),
    .dma_data_in(dma_data_in), .dma_data_out(dma_data_out)
  );

  always #5 clk = ~clk;

  // Crossbar model: word address = {local, bank}, one-cycle read latency.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 32'hC0DE_0000 + i;
      loaded <= 1'b1;
    end else begin
      if (dma_write_en) mem[{dma_local_addr, dma_bank_sel}] <= dma_data_in;
      if (dma_read_en) dma_data_out <= mem[{dma_local_addr, dma_bank_sel}];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    logic pop;
    if (!rst_n) begin
      m_occ = 0;
      m_infl = 0;
    end else begin
      pop = rd_valid & rd_ready;
      check("rd_valid_vs_occ", rd_valid, m_occ != 0);
      if (pop) begin
        check("rd_beat_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) check("rd_data", rd_data, exp_rd.pop_front());
      end
      if (dma_write_en) begin
        check("wr_beat_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0)
          check("wr_bank_local_data", {dma_bank_sel, dma_local_addr, dma_data_in},
                exp_wr.pop_front());
      end
      if (dma_read_en) begin
        check("rd_issue_expected", reads_left != 0, 1);
        if (reads_left > 0) reads_left--;
        check("rd_issue_occ_lt2", (m_occ - int'(pop) + m_infl) < 2, 1);
      end
      if (dma_write_en | dma_read_en) check("en_exclusive", dma_write_en & dma_read_en, 0);
      if (done) begin
        check("done_expected", exp_done != 0, 1);
        if (exp_done > 0) exp_done--;
      end
      if (err) begin
        check("err_expected", exp_err != 0, 1);
        if (exp_err > 0) exp_err--;
      end
      m_occ = m_occ + m_infl - int'(pop);
      m_infl = int'(dma_read_en);
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send_cmd(input logic dir, input logic [11:0] a, input logic [12:0] l);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_addr  = a;
    cmd_len   = l;
    @(negedge clk);
    check("cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_write(input logic [11:0] a, input logic [31:0] base, input int n);
    exp_done++;
    send_cmd(1'b0, a, 13'(n));
    wr_valid = 1'b1;
    for (int i = 0; i < n; i++) begin
      wr_data = base + i;
      @(negedge clk);
      check("wr_beat_cycle", dma_write_en, 1);
      @(posedge clk);
      #1;
    end
    wr_valid = 1'b0;
    @(negedge clk);
    check("wr_done_next_cycle", done, 1);
    check("wr_idle_after", busy, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_read(input logic [11:0] a, input int n, input int pat, output int beats,
                          output int span);
    int first, last, c;
    bit got;
    for (int i = 0; i < n; i++) exp_rd.push_back(32'hC0DE_0000 + a + i);
    exp_done++;
    reads_left += n;
    rd_ready = 1'b1;
    send_cmd(1'b1, a, 13'(n));
    beats = 0; first = 0; last = 0; got = 0; c = 0;
    while (!got && c < 100) begin
      rd_ready = (pat == 0) ? 1'b1 : ((c % 3) == 0);
      @(negedge clk);
      if (rd_valid & rd_ready) begin
        if (beats == 0) first = c;
        last = c;
        beats++;
      end
      if (done) got = 1;
      @(posedge clk);
      #1;
      c++;
    end
    check("rd_done_seen", got, 1);
    span = last - first;
    rd_ready = 1'b0;
  endtask

  initial begin
    int beats, span, nb, c;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_ctrl_zero", {busy, done, err, dma_write_en, dma_read_en, rd_valid, wr_ready}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("cmd_ready_after_release", cmd_ready, 1);
    @(posedge clk);
    #1;

    run_read(12'd0, 8, 0, beats, span);
    check("rd8_beats", beats, 8);
    check("rd8_back_to_back", span, 7);

    run_read(12'd16, 6, 1, beats, span);
    check("rd6_toggle_beats", beats, 6);

    exp_wr.push_back({2'd1, 10'd1, 32'h1111_0000});
    exp_wr.push_back({2'd2, 10'd1, 32'h1111_0001});
    exp_wr.push_back({2'd3, 10'd1, 32'h1111_0002});
    exp_wr.push_back({2'd0, 10'd2, 32'h1111_0003});
    run_write(12'd5, 32'h1111_0000, 4);

`ifdef DMA_XFER_RANGE_CHECK_EN
    exp_err++;
    send_cmd(1'b0, 12'd4094, 13'd4);
    nb = 0;
    wr_valid = 1'b1;
    wr_data = 32'h2222_0000;
    @(negedge clk);
    check("range_err_pulse", err, 1);
    check("range_no_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      if (dma_write_en) nb++;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check("range_zero_writes", nb, 0);
    check("range_idle", busy, 0);
    @(posedge clk);
    #1;
`else
    exp_wr.push_back({2'd2, 10'd1023, 32'h2222_0000});
    exp_wr.push_back({2'd3, 10'd1023, 32'h2222_0001});
    exp_wr.push_back({2'd0, 10'd0, 32'h2222_0002});
    exp_wr.push_back({2'd1, 10'd0, 32'h2222_0003});
    run_write(12'd4094, 32'h2222_0000, 4);
`endif

    exp_done++;
    send_cmd(1'b1, 12'd100, 13'd0);
    @(negedge clk);
    check("len0_done", done, 1);
    for (int i = 0; i < 3; i++) begin
      check("len0_busy_low", busy, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;

    // Abort a len=10 read during its third delivered beat.
    for (int i = 0; i < 10; i++) exp_rd.push_back(32'hC0DE_0020 + i);
    reads_left += 10;
    rd_ready = 1'b1;
    send_cmd(1'b1, 12'd32, 13'd10);
    nb = 0;
    c = 0;
    while (nb < 3 && c < 30) begin
      @(negedge clk);
      if (rd_valid & rd_ready) nb++;
      if (nb < 3) begin
        @(posedge clk);
        #1;
      end
      c++;
    end
    check("rst_third_beat_reached", nb, 3);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_ctrl_zero", {cmd_ready, busy, done, err, dma_write_en, dma_read_en,
                              dma_bank_sel, dma_local_addr, rd_valid, wr_ready}, 0);
    check("abort_data_zero", {dma_data_in, rd_data}, 0);
    exp_rd.delete();
    reads_left = 0;
    rd_ready = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_cmd_ready", cmd_ready, 1);
    repeat (5) @(negedge clk);
    check("abort_idle", busy, 0);

    check("end_wr_queue_empty", exp_wr.size(), 0);
    check("end_rd_queue_empty", exp_rd.size(), 0);
    check("end_all_done_seen", exp_done, 0);
    check("end_all_err_seen", exp_err, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
